vending_machine_param: RTL and testbench

Parametrised successor of the single-item vending controller. Serves `NUM_ITEMS` items, each with its own cost and stock counter. Accepts NTD 10/5/1 coins and pays change greedily from a per-denomination coin bank. Adds sold-out detection, rollback with refund, a refund-failure fault, and a restock command, and keeps the p/q/r property outputs for formal checking.

---
 rtl/vending_pkg.sv | 45 ++++
 rtl/vending_coin_bank.sv | 50 +++++
 rtl/vending_machine_param.sv | 207 ++++++++++++++++++++
 tb/tb_vending_machine_param.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller:
// service encoding, coin denominations and cost-table slicing.
package vending_pkg;

   typedef enum logic [1:0] {
      SVC_OFF  = 2'd0,
      SVC_ON   = 2'd1,
      SVC_BUSY = 2'd2
   } service_t;

   typedef enum logic [1:0] {
      C10 = 2'd0,
      C5  = 2'd1,
      C1  = 2'd2
   } coin_type_t;

   localparam int unsigned DENOM_10 = 10;
   localparam int unsigned DENOM_5  = 5;
   localparam int unsigned DENOM_1  = 1;
   localparam int          NUM_DENOM = 3;

   // Widest packed cost table the slicing helper accepts.
   localparam int COST_TABLE_MAX_W = 256;

   function automatic int unsigned denom_value(input coin_type_t c);
      case (c)
         C10:     return DENOM_10;
         C5:      return DENOM_5;
         default: return DENOM_1;
      endcase
   endfunction

   function automatic logic [31:0] cost_slice(input logic [COST_TABLE_MAX_W-1:0] table_bits,
                                              input int slice, input int val_w);
      logic [COST_TABLE_MAX_W-1:0] shifted;
      logic [31:0]                 res;
      shifted = table_bits >> (slice * val_w);
      res     = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < val_w) res[b] = shifted[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/vending_coin_bank.sv
// One denomination of the coin bank: stored-coin counter plus the
// coin-out counter that shows change dispensed for the current sale.
module vending_coin_bank
   import vending_pkg::*;
#(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned INIT_COIN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             add_en,
   input  logic [1:0]       add_count,
   input  logic             dispense,
   input  logic             rollback,
   input  logic             reload,
   input  logic             clear_out,
   output logic [CNT_W-1:0] bank,
   output logic [CNT_W-1:0] out_count
);

   localparam int unsigned SUM_W = CNT_W + 1;

   logic [SUM_W-1:0] add_sum;
   logic [SUM_W-1:0] back_sum;

   assign add_sum  = {1'b0, bank} + SUM_W'(add_count);
   assign back_sum = {1'b0, bank} + {1'b0, out_count};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank      <= CNT_W'(INIT_COIN);
         out_count <= '0;
      end else if (reload) begin
         bank <= CNT_W'(INIT_COIN);
      end else if (rollback) begin
         bank      <= back_sum[CNT_W] ? '1 : back_sum[CNT_W-1:0];
         out_count <= '0;
      end else if (add_en) begin
         bank      <= add_sum[CNT_W] ? '1 : add_sum[CNT_W-1:0];
         out_count <= '0;
      end else if (dispense) begin
         bank      <= bank - CNT_W'(1);
         out_count <= out_count + CNT_W'(1);
      end else if (clear_out) begin
         out_count <= '0;
      end
   end

endmodule

// File: rtl/vending_machine_param.sv
// Multi-item vending controller: takes coins with a request, checks stock
// and price, pays change greedily from the coin bank, rolls back on shortage.
module vending_machine_param
   import vending_pkg::*;
#(
   parameter int                         NUM_ITEMS  = 4,
   parameter int                         VAL_W      = 8,
   parameter int                         CNT_W      = 4,
   parameter int                         INIT_COIN  = 2,
   parameter int                         INIT_STOCK = 3,
   parameter logic [NUM_ITEMS*VAL_W-1:0] COST_TABLE = {8'd25, 8'd17, 8'd12, 8'd8},
   localparam int                        ITEM_W     = $clog2(NUM_ITEMS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           coin_in_10,
   input  logic [1:0]           coin_in_5,
   input  logic [1:0]           coin_in_1,
   input  logic [ITEM_W-1:0]    item_in,
   input  logic                 restock,
   output logic [CNT_W-1:0]     coin_out_10,
   output logic [CNT_W-1:0]     coin_out_5,
   output logic [CNT_W-1:0]     coin_out_1,
   output logic [ITEM_W-1:0]    item_out,
   output logic [1:0]           service_out,
   output logic [NUM_ITEMS-1:0] sold_out,
   output logic                 fault,
   output logic                 p,
   output logic                 q,
   output logic                 r
);

   localparam logic [COST_TABLE_MAX_W-1:0] COST_BITS = COST_TABLE_MAX_W'(COST_TABLE);

   service_t          state, state_n;
   coin_type_t        coin_type, coin_type_n;
   logic [VAL_W-1:0]  input_value, input_value_n, service_value, service_value_n;
   logic [ITEM_W-1:0] item_out_n;
   logic              ready, ready_n, refunding, refunding_n, fault_n, initialized;
   logic [CNT_W-1:0]  stock [NUM_ITEMS];
   logic [CNT_W-1:0]  stock_n [NUM_ITEMS];
   logic [CNT_W-1:0]  cur_stock, bank_sel;
   logic [CNT_W-1:0]  bank [NUM_DENOM];
   logic [CNT_W-1:0]  out_count [NUM_DENOM];
   logic [1:0]        coin_cnt [NUM_DENOM];
   logic [NUM_DENOM-1:0] dispense;
   logic              add_en, rollback, reload, clear_out, item_valid;
   logic [VAL_W-1:0]  d_val, out_exchange, item_cost;

   function automatic logic [VAL_W-1:0] cost_of(input logic [ITEM_W-1:0] item);
      if (item == '0 || int'(item) > NUM_ITEMS) return '0;
      return VAL_W'(cost_slice(COST_BITS, int'(item) - 1, VAL_W));
   endfunction

   assign coin_cnt[C10] = coin_in_10;
   assign coin_cnt[C5]  = coin_in_5;
   assign coin_cnt[C1]  = coin_in_1;

   for (genvar i = 0; i < NUM_DENOM; i++) begin : g_bank
      vending_coin_bank #(.CNT_W(CNT_W), .INIT_COIN(INIT_COIN)) u_bank (
         .clk       (clk),
         .reset     (reset),
         .add_en    (add_en),
         .add_count (coin_cnt[i]),
         .dispense  (dispense[i]),
         .rollback  (rollback),
         .reload    (reload),
         .clear_out (clear_out),
         .bank      (bank[i]),
         .out_count (out_count[i])
      );
   end

   assign coin_out_10 = out_count[C10];
   assign coin_out_5  = out_count[C5];
   assign coin_out_1  = out_count[C1];
   assign service_out = state;
   assign bank_sel    = bank[coin_type];
   assign d_val       = VAL_W'(denom_value(coin_type));
   assign item_cost   = cost_of(item_out);
   assign item_valid  = (item_out != '0) && (int'(item_out) <= NUM_ITEMS);

   always_comb begin
      cur_stock = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         sold_out[i] = (stock[i] == '0);
         if (ITEM_W'(i + 1) == item_out) cur_stock = stock[i];
      end
   end

   assign out_exchange = VAL_W'(DENOM_10) * VAL_W'(coin_out_10)
                       + VAL_W'(DENOM_5)  * VAL_W'(coin_out_5)
                       + VAL_W'(coin_out_1);

   assign p = initialized && state == SVC_OFF && !fault
            && (out_exchange + item_cost != input_value);
   assign q = initialized && state == SVC_BUSY && ready
            && (out_exchange + service_value != input_value - item_cost);
   assign r = initialized && state == SVC_ON
            && ((|coin_out_10) || (|coin_out_5) || (|coin_out_1) || service_value != '0);

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_n         = state;
      input_value_n   = input_value;
      service_value_n = service_value;
      item_out_n      = item_out;
      ready_n         = ready;
      refunding_n     = refunding;
      coin_type_n     = coin_type;
      fault_n         = fault;
      stock_n         = stock;
      add_en          = 1'b0;
      rollback        = 1'b0;
      reload          = 1'b0;
      clear_out       = 1'b0;
      dispense        = '0;

      case (state)
         SVC_ON: begin
            if (item_in != '0) begin
               input_value_n = VAL_W'(DENOM_10 * int'(coin_in_10) + DENOM_5 * int'(coin_in_5)
                                      + int'(coin_in_1));
               add_en      = 1'b1;
               item_out_n  = item_in;
               ready_n     = 1'b0;
               refunding_n = 1'b0;
               fault_n     = 1'b0;
               coin_type_n = C10;
               state_n     = SVC_BUSY;
            end else if (restock) begin
               reload = 1'b1;
               for (int i = 0; i < NUM_ITEMS; i++) stock_n[i] = CNT_W'(INIT_STOCK);
            end
         end
         SVC_BUSY: begin
            if (!ready) begin
               if (!item_valid || cur_stock == '0 || input_value < item_cost) begin
                  service_value_n = input_value;
                  item_out_n      = '0;
                  refunding_n     = 1'b1;
               end else begin
                  service_value_n = input_value - item_cost;
               end
               ready_n = 1'b1;
            end else if (service_value >= d_val && bank_sel != '0) begin
               dispense[coin_type] = 1'b1;
               service_value_n     = service_value - d_val;
            end else if (coin_type == C10) begin
               coin_type_n = C5;
            end else if (coin_type == C5) begin
               coin_type_n = C1;
            end else if (service_value == '0) begin
               state_n = SVC_OFF;
               for (int i = 0; i < NUM_ITEMS; i++) begin
                  if (ITEM_W'(i + 1) == item_out) stock_n[i] = stock[i] - CNT_W'(1);
               end
            end else if (!refunding) begin
               // Not enough 1-coins for the change: give everything back instead.
               rollback        = 1'b1;
               service_value_n = input_value;
               item_out_n      = '0;
               refunding_n     = 1'b1;
               coin_type_n     = C10;
            end else begin
               state_n = SVC_OFF;
               fault_n = 1'b1;
            end
         end
         SVC_OFF: begin
            clear_out       = 1'b1;
            item_out_n      = '0;
            fault_n         = 1'b0;
            service_value_n = '0;
            state_n         = SVC_ON;
         end
         default: state_n = SVC_ON;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= SVC_ON;
         input_value   <= '0;
         service_value <= '0;
         item_out      <= '0;
         ready         <= 1'b0;
         refunding     <= 1'b0;
         coin_type     <= C10;
         fault         <= 1'b0;
         initialized   <= 1'b1;
         // NOTE: the stock table is a handful of counters with a defined power-up value, so it is reset like any register.
         for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= CNT_W'(INIT_STOCK);
      end else begin
         state         <= state_n;
         input_value   <= input_value_n;
         service_value <= service_value_n;
         item_out      <= item_out_n;
         ready         <= ready_n;
         refunding     <= refunding_n;
         coin_type     <= coin_type_n;
         fault         <= fault_n;
         stock         <= stock_n;
      end
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: purchases, change, refunds,
// rollback, sold-out/restock, invalid item and reset during dispense.
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] coin_in_10, coin_in_5, coin_in_1;
   logic [2:0] item_in;
   logic       restock;
   logic [3:0] coin_out_10, coin_out_5, coin_out_1;
   logic [2:0] item_out;
   logic [1:0] service_out;
   logic [3:0] sold_out;
   logic       fault, p, q, r;

   int   checks = 0;
   int   errors = 0;
   logic pqr_seen;

   vending_machine_param dut (
      .clk         (clk),
      .reset       (reset),
      .coin_in_10  (coin_in_10),
      .coin_in_5   (coin_in_5),
      .coin_in_1   (coin_in_1),
      .item_in     (item_in),
      .restock     (restock),
      .coin_out_10 (coin_out_10),
      .coin_out_5  (coin_out_5),
      .coin_out_1  (coin_out_1),
      .item_out    (item_out),
      .service_out (service_out),
      .sold_out    (sold_out),
      .fault       (fault),
      .p           (p),
      .q           (q),
      .r           (r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_svc_on"}, 32'(service_out), 1);
      check({tag, "_item"},   32'(item_out), 0);
      check({tag, "_coins"},  32'({coin_out_10, coin_out_5, coin_out_1}), 0);
      check({tag, "_fault"},  32'(fault), 0);
      check({tag, "_pqr"},    32'({p, q, r}), 0);
   endtask

   // One purchase: present the request for one edge, wait for OFF, check, return to ON.
   task automatic txn(input string tag, input logic [1:0] c10, input logic [1:0] c5,
                      input logic [1:0] c1, input logic [2:0] item, input int exp_busy,
                      input int e10, input int e5, input int e1, input int e_item);
      int n;
      coin_in_10 = c10;
      coin_in_5  = c5;
      coin_in_1  = c1;
      item_in    = item;
      @(negedge clk);
      coin_in_10 = '0;
      coin_in_5  = '0;
      coin_in_1  = '0;
      item_in    = '0;
      pqr_seen   = 1'b0;
      n          = 0;
      while (service_out === 2'd2 && n < 200) begin
         pqr_seen = pqr_seen | p | q | r;
         n++;
         @(negedge clk);
      end
      pqr_seen = pqr_seen | p | q | r;
      check({tag, "_busy_cycles"}, 32'(n), exp_busy);
      check({tag, "_svc_off"},     32'(service_out), 0);
      check({tag, "_out10"},       32'(coin_out_10), e10);
      check({tag, "_out5"},        32'(coin_out_5), e5);
      check({tag, "_out1"},        32'(coin_out_1), e1);
      check({tag, "_item_out"},    32'(item_out), e_item);
      check({tag, "_fault"},       32'(fault), 0);
      check({tag, "_pqr_seen"},    32'(pqr_seen), 0);
      @(negedge clk);
      check_idle({tag, "_after"});
   endtask

   initial begin
      reset      = 1'b1;
      coin_in_10 = '0;
      coin_in_5  = '0;
      coin_in_1  = '0;
      item_in    = '0;
      restock    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_idle("reset");
      check("reset_sold_out", 32'(sold_out), 0);

      // Exact payment, then change 3, then under-payment refund of item 3.
      txn("exact",  2'd0, 2'd1, 2'd3, 3'd1, 4, 0, 0, 0, 1);
      txn("change", 2'd1, 2'd0, 2'd1, 3'd1, 7, 0, 0, 3, 1);
      txn("refund", 2'd0, 2'd2, 2'd0, 3'd3, 5, 1, 0, 0, 0);
      check("refund_sold_out", 32'(sold_out), 0);

      // Second 10-coin purchase finds no 1-coins left and rolls back.
      do_reset();
      txn("first_ten", 2'd1, 2'd0, 2'd0, 3'd1, 6, 0, 0, 2, 1);
      txn("rollback",  2'd1, 2'd0, 2'd0, 3'd1, 8, 1, 0, 0, 0);
      check("rollback_sold_out", 32'(sold_out), 0);

      // Sell out item 1, get refunded, restock, buy again.
      do_reset();
      for (int k = 0; k < 3; k++) txn("drain", 2'd0, 2'd1, 2'd3, 3'd1, 4, 0, 0, 0, 1);
      check("drained_sold_out", 32'(sold_out), 32'b0001);
      txn("sold_refund", 2'd0, 2'd1, 2'd3, 3'd1, 8, 0, 1, 3, 0);
      check("sold_refund_sold_out", 32'(sold_out), 32'b0001);
      restock = 1'b1;
      @(negedge clk);
      restock = 1'b0;
      check("restock_sold_out", 32'(sold_out), 0);
      check_idle("restock");
      txn("after_restock", 2'd0, 2'd1, 2'd3, 3'd1, 4, 0, 0, 0, 1);
      check("after_restock_sold_out", 32'(sold_out), 0);

      // Item code beyond NUM_ITEMS is refunded.
      txn("bad_item", 2'd0, 2'd0, 2'd2, 3'd5, 6, 0, 0, 2, 0);

      // Reset while 1-coins are being dispensed.
      coin_in_10 = 2'd1;
      item_in    = 3'd1;
      @(negedge clk);
      coin_in_10 = '0;
      item_in    = '0;
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(service_out), 2);
      check("mid_out1", 32'(coin_out_1), 1);
      do_reset();
      check_idle("mid_reset");
      check("mid_reset_sold_out", 32'(sold_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
